muldiv_seq: RTL and testbench

Iterative multi-cycle RV64M multiply/divide unit that takes the `*`, `/` and `%` operations off the single-cycle ALU path in the NPC execute stage. It accepts one operation at a time over a valid/ready handshake and sequences a radix-2 shift-add multiplier or a restoring divider for 64 iterations. It resolves the divide-by-zero and signed-overflow special cases in one cycle and returns an RV64M-conformant 64-bit result with a writeback tag. The pipeline can abort it at any time with a flush.

---
 rtl/muldiv_pkg.sv | 82 ++++++++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_iter.sv | 33 +++
 rtl/muldiv_seq.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and op-class helpers for the iterative
// RV64M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_word(input logic [3:0] op);
        case (op)
            OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: is_word = 1'b1;
            default:                                      is_word = 1'b0;
        endcase
    endfunction

    // W ops whose 32-bit operands are sign-extended before use
    function automatic logic is_wsext(input logic [3:0] op);
        case (op)
            OP_MULW, OP_DIVW, OP_REMW: is_wsext = 1'b1;
            default:                   is_wsext = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: is_div = 1'b1;
            default:                             is_div = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        case (op)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: is_rem = 1'b1;
            default:                           is_rem = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_a(input logic [3:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW: is_signed_a = 1'b1;
            default:                                             is_signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input logic [3:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW: is_signed_b = 1'b1;
            default:                                  is_signed_b = 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        is_illegal = (op > 4'd12);
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        sext32 = {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response channel between the execute stage and muldiv_seq.
interface muldiv_if #(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag
    );
endinterface

// File: rtl/muldiv_iter.sv
// One combinational radix-2 step: shift-add multiply or restoring divide.
// acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic [0:0]        div_mode_s,
    input  logic [2*XLEN-1:0] acc_s,
    input  logic [XLEN-1:0]   opb_s,
    output logic [2*XLEN-1:0] acc_nx_s
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Single iteration of the selected algorithm
    always_comb begin
        sum_s     = {1'b0, acc_s[2*XLEN-1:XLEN]} + (acc_s[0] ? {1'b0, opb_s} : {(XLEN+1){1'b0}});
        shifted_s = {acc_s[2*XLEN-1:XLEN], acc_s[XLEN-1]};
        diff_s    = shifted_s - {1'b0, opb_s};
        if (div_mode_s == 1'b1) begin
            // A borrow out means the trial subtract went negative: restore
            if (diff_s[XLEN]) begin
                acc_nx_s = {shifted_s[XLEN-1:0], acc_s[XLEN-2:0], 1'b0};
            end else begin
                acc_nx_s = {diff_s[XLEN-1:0], acc_s[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_nx_s = {sum_s, acc_s[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide unit: 64 radix-2 iterations on operand
// magnitudes, one-cycle special cases, sign/W fix-up, flushable at any time.
module muldiv_seq #(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    muldiv_if.slave  bus
);
    import muldiv_pkg::*;

    state_e            state_r;
    state_e            state_nx_s;
    logic [6:0]        cnt_r;
    logic [2*XLEN-1:0] acc_r;
    logic [2*XLEN-1:0] acc_nx_s;
    logic [XLEN-1:0]   opb_r;
    logic [3:0]        op_r;
    logic              negp_r;
    logic              nega_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   out_res_r;
    logic [TAGW-1:0]   out_tag_r;

    logic [XLEN-1:0]   a_ext_s;
    logic [XLEN-1:0]   b_ext_s;
    logic              sa_s;
    logic              sb_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              divzero_s;
    logic              ovf_s;
    logic              special_s;
    logic [XLEN-1:0]   spec_res_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res_s;
    logic              accept_s;
    logic [0:0]        div_mode_s;

    muldiv_iter u_iter (
        .div_mode_s (div_mode_s),
        .acc_s      (acc_r),
        .opb_s      (opb_r),
        .acc_nx_s   (acc_nx_s)
    );

    // Operand preparation and special-case detection on the offered request
    always_comb begin
        if (is_word(bus.in_op)) begin
            if (is_wsext(bus.in_op)) begin
                a_ext_s = sext32(bus.in_a[31:0]);
                b_ext_s = sext32(bus.in_b[31:0]);
            end else begin
                a_ext_s = {32'd0, bus.in_a[31:0]};
                b_ext_s = {32'd0, bus.in_b[31:0]};
            end
        end else begin
            a_ext_s = bus.in_a;
            b_ext_s = bus.in_b;
        end
        sa_s      = is_signed_a(bus.in_op) & a_ext_s[XLEN-1];
        sb_s      = is_signed_b(bus.in_op) & b_ext_s[XLEN-1];
        mag_a_s   = sa_s ? -a_ext_s : a_ext_s;
        mag_b_s   = sb_s ? -b_ext_s : b_ext_s;
        divzero_s = is_div(bus.in_op) && (b_ext_s == 64'd0);
        case (bus.in_op)
            OP_DIV, OP_REM:
                ovf_s = (bus.in_a == 64'h8000_0000_0000_0000) && (bus.in_b == 64'hFFFF_FFFF_FFFF_FFFF);
            OP_DIVW, OP_REMW:
                ovf_s = (bus.in_a[31:0] == 32'h8000_0000) && (bus.in_b[31:0] == 32'hFFFF_FFFF);
            default:
                ovf_s = 1'b0;
        endcase
        special_s = divzero_s | ovf_s | is_illegal(bus.in_op);
        // Overflow quotient equals the dividend, so both special paths share it
        if (is_illegal(bus.in_op)) begin
            spec_res_s = 64'd0;
        end else if (divzero_s && !is_rem(bus.in_op)) begin
            spec_res_s = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (ovf_s && is_rem(bus.in_op)) begin
            spec_res_s = 64'd0;
        end else if (is_word(bus.in_op)) begin
            spec_res_s = sext32(bus.in_a[31:0]);
        end else begin
            spec_res_s = bus.in_a;
        end
    end

    // Sign correction and result selection for the FIX state
    always_comb begin
        prod_s = negp_r ? -acc_r : acc_r;
        quo_s  = negp_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
        rem_s  = nega_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                        fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_s = prod_s[2*XLEN-1:XLEN];
            OP_MULW:                       fix_res_s = sext32(prod_s[31:0]);
            OP_DIV, OP_DIVU:               fix_res_s = quo_s;
            OP_REM, OP_REMU:               fix_res_s = rem_s;
            OP_DIVW, OP_DIVUW:             fix_res_s = sext32(quo_s[31:0]);
            OP_REMW, OP_REMUW:             fix_res_s = sext32(rem_s[31:0]);
            default:                       fix_res_s = 64'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; flush overrides accept and the DONE handshake
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nx_s = special_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CALC: state_nx_s = (cnt_r == 7'd0) ? ST_FIX : ST_CALC;
                ST_FIX:  state_nx_s = ST_DONE;
                ST_DONE: state_nx_s = bus.out_ready ? ST_IDLE : ST_DONE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: accept strobe and iteration mode
    always_comb begin
        accept_s   = bus.in_valid && (state_r == ST_IDLE) && !flush;
        div_mode_s = is_div(op_r);
    end

    // Datapath, counter and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= 7'd0;
            acc_r       <= {(2*XLEN){1'b0}};
            opb_r       <= {XLEN{1'b0}};
            op_r        <= 4'd0;
            negp_r      <= 1'b0;
            nega_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_res_r   <= {XLEN{1'b0}};
            out_tag_r   <= {TAGW{1'b0}};
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            if (flush) begin
                cnt_r <= 7'd0;
            end else if (accept_s) begin
                op_r      <= bus.in_op;
                out_tag_r <= bus.in_tag;
                negp_r    <= sa_s ^ sb_s;
                nega_r    <= sa_s;
                acc_r     <= {{XLEN{1'b0}}, mag_a_s};
                opb_r     <= mag_b_s;
                if (special_s) begin
                    cnt_r     <= 7'd0;
                    out_res_r <= spec_res_s;
                end else begin
                    cnt_r <= 7'd63;
                end
            end else if (state_r == ST_CALC) begin
                acc_r <= acc_nx_s;
                if (cnt_r != 7'd0) begin
                    cnt_r <= cnt_r - 7'd1;
                end
            end else if (state_r == ST_FIX) begin
                out_res_r <= fix_res_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_res   = out_res_r;
    assign bus.out_tag   = out_tag_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latency,
// special cases, backpressure, flush and mid-operation reset.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    muldiv_if #(.XLEN(64), .TAGW(5)) bus ();

    muldiv_seq #(.XLEN(64), .TAGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid; lat counts cycles after the accept edge (1 = next cycle)
    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        start_op(op, a, b, tag);
        wait_valid(lat);
        chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_res"}, bus.out_res, exp);
        chk({name, "_tag"}, {59'd0, bus.out_tag}, {59'd0, tag});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] held_res;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = 64'd0;
        bus.in_b      = 64'd0;
        bus.in_tag    = 5'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_res", bus.out_res, 64'd0);
        chk("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
        rst_n = 1'b1;

        run_op("mul_6x7", 4'd0, 64'd6, 64'd7, 5'd3, 64'd42, 66);
        run_op("mulhu_max", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
               64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh_m1", 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd0, 66);
        run_op("mulhsu", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("mulw", 4'd8, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("divu_zero", 4'd5, 64'd5, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_zero", 4'd6, 64'd5, 64'd0, 5'd9, 64'd5, 1);
        run_op("remuw_zero", 4'd12, 64'h1_8000_0000, 64'd0, 5'd10, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("div_ovf", 4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
               64'h8000_0000_0000_0000, 1);
        run_op("remw_ovf", 4'd11, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12, 64'd0, 1);
        run_op("illegal", 4'd14, 64'd9, 64'd3, 5'd13, 64'd0, 1);
        run_op("divw", 4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("remw", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div_neg", 4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd16, 64'hFFFF_FFFF_FFFF_FFF2, 66);
        run_op("rem_neg", 4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("divu", 4'd5, 64'd100, 64'd7, 5'd18, 64'd14, 66);

        // Backpressure: result held for 10 cycles with out_ready low
        start_op(4'd0, 64'd5, 64'd5, 5'd19);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'd66);
        held_res = 64'd25;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_res", bus.out_res, held_res);
            chk("bp_tag", {59'd0, bus.out_tag}, 64'd19);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("bp_release_valid", {63'd0, bus.out_valid}, 64'd0);

        // Flush mid-CALC, then a fresh op straight after
        start_op(4'd0, 64'd12, 64'd12, 5'd20);
        repeat (30) @(negedge clk);
        chk("fl_busy", {63'd0, bus.in_ready}, 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
        run_op("fl_mul_3x3", 4'd0, 64'd3, 64'd3, 5'd21, 64'd9, 66);

        // Flush in IDLE blocks an offered request
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'd5;
        bus.in_a     = 64'd1;
        bus.in_b     = 64'd0;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        chk("fl_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("fl_idle_ready", {63'd0, bus.in_ready}, 64'd1);

        // Reset mid-CALC discards the operation
        start_op(4'd0, 64'd11, 64'd11, 5'd22);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rs_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rs_out_tag", {59'd0, bus.out_tag}, 64'd0);
        run_op("rs_mul_3x3", 4'd0, 64'd3, 64'd3, 5'd23, 64'd9, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
